// File: rtl/gb_intctl_if.sv
// Bus bundle between the CPU/peripherals and the interrupt controller:
// register access, request lines and the CPU interrupt handshake.
interface gb_intctl_if;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        load;
  logic        store;
  logic [7:0]  rdata;
  logic        cs;
  logic [4:0]  irq_src;
  logic        intreq;
  logic [15:0] intaddress;
  logic        intack;

  modport master (
    output address, wdata, load, store, irq_src, intack,
    input  rdata, cs, intreq, intaddress
  );

  modport slave (
    input  address, wdata, load, store, irq_src, intack,
    output rdata, cs, intreq, intaddress
  );
endinterface

// File: rtl/gb_intctl.sv
// Game Boy style interrupt controller: IF/IE registers, rising-edge capture of
// peripheral requests, fixed-priority vector generation and acknowledge clearing.
module gb_intctl (
  input  logic         clock,
  input  logic         resetn,
  gb_intctl_if.slave   bus
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic [4:0] src_q;
  logic       ack_q;

  logic [4:0] rise;
  logic       ack_rise;
  logic [4:0] pend;
  logic [2:0] sel;
  logic [4:0] ack_clr;
  logic       hit_if, hit_ie;
  logic       wr_if, wr_ie;
  logic       unused_load;

  // Reads are purely address-decoded; the read strobe has no effect here.
  assign unused_load = bus.load;

  assign hit_if = (bus.address == ADDR_IF);
  assign hit_ie = (bus.address == ADDR_IE);
  assign wr_if  = bus.store && hit_if;
  assign wr_ie  = bus.store && hit_ie;

  assign rise     = bus.irq_src & ~src_q;
  assign ack_rise = bus.intack & ~ack_q;
  assign pend     = if_q & ie_q[4:0];

  // Lowest pending bit wins: scan from the top so bit 0 overrides.
  always_comb begin
    sel = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) sel = 3'(i);
    end
  end

  assign ack_clr = (ack_rise && (pend != 5'd0)) ? (5'd1 << sel) : 5'd0;

  // A fresh edge is OR-ed in last so it beats both a write and an acknowledge.
  assign if_d = ((wr_if ? bus.wdata[4:0] : if_q) & ~ack_clr) | rise;
  assign ie_d = wr_ie ? bus.wdata : ie_q;

  assign bus.intreq     = (pend != 5'd0);
  assign bus.intaddress = bus.intreq ? (16'h0040 + {10'd0, sel, 3'd0}) : 16'h0000;
  assign bus.cs         = hit_if || hit_ie;
  assign bus.rdata      = hit_if ? {3'b111, if_q} :
                          hit_ie ? ie_q : 8'hFF;

  // Source history resets to all-ones so lines already high at release stay quiet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      if_q  <= 5'd0;
      ie_q  <= 8'd0;
      src_q <= 5'h1F;
      ack_q <= 1'b0;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      src_q <= bus.irq_src;
      ack_q <= bus.intack;
    end
  end

endmodule
